// File: rtl/sysmem_arbiter.sv
// Two-port arbiter and fixed four-state sequencer for the byte-banked system SRAM.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with a one-cycle ready pulse.
module sysmem_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int AW          = 11
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          m0_valid,
   input  logic [31:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic [3:0]    m0_wstrb,
   output logic          m0_ready,
   output logic [31:0]   m0_rdata,
   input  logic          m1_valid,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic [3:0]    m1_wstrb,
   output logic          m1_ready,
   output logic [31:0]   m1_rdata,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   output logic [3:0]    sram_we,
   output logic          sram_ce,
   input  logic [31:0]   sram_rdata,
   output logic [1:0]    grant,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    we_q, we_d;
   logic          ce_q, ce_d;
   logic          inrange_q, inrange_d;
   logic          busy_q, busy_d;
   logic          ready0_q, ready0_d;
   logic          ready1_q, ready1_d;
   logic [31:0]   rdata0_q, rdata0_d;
   logic [31:0]   rdata1_q, rdata1_d;

   logic          pick1;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_wstrb;
   logic          req_inrange;
   logic [31:0]   cap_data;
   logic          unused_addr_lsbs;

   // last_q = 1 means port 1 owned the previous transaction, so port 0 wins the next tie.
   always_comb begin
      if (m0_valid && m1_valid) begin
         pick1 = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
      end else begin
         pick1 = m1_valid;
      end
   end

   assign req_addr         = pick1 ? m1_addr  : m0_addr;
   assign req_wdata        = pick1 ? m1_wdata : m0_wdata;
   assign req_wstrb        = pick1 ? m1_wstrb : m0_wstrb;
   assign req_inrange      = (req_addr[31:AW+2] == '0);
   assign cap_data         = inrange_q ? sram_rdata : 32'h0;
   assign unused_addr_lsbs = ^req_addr[1:0];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      inrange_d = inrange_q;
      busy_d    = busy_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      we_d      = 4'h0;
      ce_d      = 1'b0;
      ready0_d  = 1'b0;
      ready1_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               state_d   = ISSUE;
               grant_d   = pick1 ? 2'b10 : 2'b01;
               addr_d    = req_addr[AW+1:2];
               wdata_d   = req_wdata;
               inrange_d = req_inrange;
               ce_d      = 1'b1;
               we_d      = req_inrange ? req_wstrb : 4'h0;
               busy_d    = 1'b1;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Banks present the addressed word during this cycle; latch it for the owner.
            state_d = DONE;
            if (grant_q[0]) begin
               rdata0_d = cap_data;
               ready0_d = 1'b1;
            end
            if (grant_q[1]) begin
               rdata1_d = cap_data;
               ready1_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = grant_q[1];
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         last_q    <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         we_q      <= 4'h0;
         ce_q      <= 1'b0;
         inrange_q <= 1'b0;
         busy_q    <= 1'b0;
         ready0_q  <= 1'b0;
         ready1_q  <= 1'b0;
         rdata0_q  <= 32'h0;
         rdata1_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         ce_q      <= ce_d;
         inrange_q <= inrange_d;
         busy_q    <= busy_d;
         ready0_q  <= ready0_d;
         ready1_q  <= ready1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign m0_ready   = ready0_q;
   assign m1_ready   = ready1_q;
   assign m0_rdata   = rdata0_q;
   assign m1_rdata   = rdata1_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign sram_we    = we_q;
   assign sram_ce    = ce_q;
   assign grant      = grant_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sysmem_arbiter.sv
// Bench for sysmem_arbiter: a round-robin instance and a fixed-priority instance share the
// master inputs; each drives its own read-first byte-banked SRAM model.
module tb_sysmem_arbiter;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;

   logic        a_m0_ready, a_m1_ready, a_sram_ce, a_busy;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_sram_wdata;
   logic [31:0] a_sram_rdata = 32'h0;
   logic [10:0] a_sram_addr;
   logic [3:0]  a_sram_we;
   logic [1:0]  a_grant;

   logic        b_m0_ready, b_m1_ready, b_sram_ce, b_busy;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_sram_wdata;
   logic [31:0] b_sram_rdata = 32'h0;
   logic [10:0] b_sram_addr;
   logic [3:0]  b_sram_we;
   logic [1:0]  b_grant;

   sysmem_arbiter #(.ROUND_ROBIN(1), .AW(11)) dut_a (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
      .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_we(a_sram_we),
      .sram_ce(a_sram_ce), .sram_rdata(a_sram_rdata), .grant(a_grant), .busy(a_busy)
   );

   sysmem_arbiter #(.ROUND_ROBIN(0), .AW(11)) dut_b (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
      .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_we(b_sram_we),
      .sram_ce(b_sram_ce), .sram_rdata(b_sram_rdata), .grant(b_grant), .busy(b_busy)
   );

   logic [31:0] mem_a [0:2047];
   logic [31:0] mem_b [0:2047];
   logic [31:0] gold  [0:2047];

   always @(posedge clk) begin
      if (a_sram_ce) begin
         a_sram_rdata <= mem_a[a_sram_addr];
         for (int i = 0; i < 4; i++)
            if (a_sram_we[i]) mem_a[a_sram_addr][8*i +: 8] <= a_sram_wdata[8*i +: 8];
      end
   end

   always @(posedge clk) begin
      if (b_sram_ce) begin
         b_sram_rdata <= mem_b[b_sram_addr];
         for (int i = 0; i < 4; i++)
            if (b_sram_we[i]) mem_b[b_sram_addr][8*i +: 8] <= b_sram_wdata[8*i +: 8];
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          exp_last;
   logic [31:0] exp_rd0, exp_rd1;

   // Transaction-level memory: returns the pre-access word (0 out of range) and applies the write.
   function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                                input logic [3:0] strb);
      logic [31:0] pre;
      if (addr[31:13] != 19'h0) return 32'h0;
      pre = gold[addr[12:2]];
      for (int i = 0; i < 4; i++)
         if (strb[i]) gold[addr[12:2]][8*i +: 8] = wdata[8*i +: 8];
      return pre;
   endfunction

   task automatic run_round(input string name, input logic [1:0] mask,
                            input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                            input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
      int          first, second, nmax;
      int          rc [2];
      logic [31:0] ra [2];
      logic [31:0] rd [2];
      logic [3:0]  rs [2];
      logic [31:0] prd [2];
      logic [3:0]  pwe [2];
      logic [1:0]  exp_g;
      logic        exp_ce;
      logic [3:0]  exp_we;
      logic [10:0] exp_adr;
      logic [31:0] exp_wd;
      ra[0] = a0; rd[0] = d0; rs[0] = s0;
      ra[1] = a1; rd[1] = d1; rs[1] = s1;
      rc[0] = 0; rc[1] = 0; prd[0] = 0; prd[1] = 0; pwe[0] = 0; pwe[1] = 0;
      if (mask == 2'b11) begin
         first  = (exp_last == 1) ? 0 : 1;
         second = 1 - first;
      end else begin
         first  = mask[1] ? 1 : 0;
         second = -1;
      end
      rc[first]  = 3;
      prd[first] = model_access(ra[first], rd[first], rs[first]);
      pwe[first] = (ra[first][31:13] == 19'h0) ? rs[first] : 4'h0;
      if (second >= 0) begin
         rc[second]  = 7;
         prd[second] = model_access(ra[second], rd[second], rs[second]);
         pwe[second] = (ra[second][31:13] == 19'h0) ? rs[second] : 4'h0;
      end
      exp_last = (second >= 0) ? second : first;
      nmax = (second >= 0) ? 8 : 4;
      m0_valid = mask[0]; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
      m1_valid = mask[1]; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
      for (int n = 1; n <= nmax; n++) begin
         @(negedge clk);
         exp_g = 2'b00; exp_ce = 1'b0; exp_we = 4'h0; exp_adr = 11'h0; exp_wd = 32'h0;
         for (int p = 0; p < 2; p++) begin
            if (rc[p] != 0 && n >= rc[p] - 2 && n <= rc[p]) begin
               exp_g[p] = 1'b1;
               if (n == rc[p] - 2) begin
                  exp_ce = 1'b1; exp_we = pwe[p]; exp_adr = ra[p][12:2]; exp_wd = rd[p];
               end
            end
         end
         if (n == rc[0]) exp_rd0 = prd[0];
         if (n == rc[1]) exp_rd1 = prd[1];
         checks++;
         if (a_grant !== exp_g) begin
            errors++; $display("FAIL %s grant n=%0d got %b exp %b", name, n, a_grant, exp_g);
         end
         checks++;
         if (a_busy !== (|exp_g)) begin
            errors++; $display("FAIL %s busy n=%0d got %b exp %b", name, n, a_busy, |exp_g);
         end
         checks++;
         if (a_sram_ce !== exp_ce) begin
            errors++; $display("FAIL %s sram_ce n=%0d got %b exp %b", name, n, a_sram_ce, exp_ce);
         end
         checks++;
         if (a_sram_we !== exp_we) begin
            errors++; $display("FAIL %s sram_we n=%0d got %b exp %b", name, n, a_sram_we, exp_we);
         end
         if (exp_ce) begin
            checks++;
            if (a_sram_addr !== exp_adr || a_sram_wdata !== exp_wd) begin
               errors++;
               $display("FAIL %s sram_addr/wdata n=%0d got %h/%h exp %h/%h",
                        name, n, a_sram_addr, a_sram_wdata, exp_adr, exp_wd);
            end
         end
         checks++;
         if (a_m0_ready !== (n == rc[0]) || a_m1_ready !== (n == rc[1])) begin
            errors++;
            $display("FAIL %s ready n=%0d got %b%b exp %b%b", name, n,
                     a_m1_ready, a_m0_ready, n == rc[1], n == rc[0]);
         end
         checks++;
         if (a_m0_rdata !== exp_rd0) begin
            errors++; $display("FAIL %s m0_rdata n=%0d got %h exp %h", name, n, a_m0_rdata, exp_rd0);
         end
         checks++;
         if (a_m1_rdata !== exp_rd1) begin
            errors++; $display("FAIL %s m1_rdata n=%0d got %h exp %h", name, n, a_m1_rdata, exp_rd1);
         end
         if (n == rc[0]) m0_valid = 1'b0;
         if (n == rc[1]) m1_valid = 1'b0;
      end
      $display("txn %s mask=%b first=m%0d rd0=%h rd1=%h", name, mask, first, exp_rd0, exp_rd1);
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      m0_valid = 1'b0; m1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      exp_last = 1; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({a_m0_ready, a_m1_ready, a_sram_ce, a_busy} !== 4'b0 || a_grant !== 2'b00 ||
          a_sram_we !== 4'h0 || a_sram_addr !== 11'h0 || a_sram_wdata !== 32'h0 ||
          a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_a got rdy=%b%b ce=%b busy=%b g=%b we=%b adr=%h wd=%h rd=%h/%h exp all 0",
                  a_m1_ready, a_m0_ready, a_sram_ce, a_busy, a_grant, a_sram_we, a_sram_addr,
                  a_sram_wdata, a_m0_rdata, a_m1_rdata);
      end
      checks++;
      if ({b_m0_ready, b_m1_ready, b_sram_ce, b_busy} !== 4'b0 || b_grant !== 2'b00 ||
          b_sram_we !== 4'h0 || b_m0_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_b got g=%b busy=%b exp 0", b_grant, b_busy);
      end
      resetn = 1'b1;
      exp_last = 1; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      $display("txn reset");
   endtask

   task automatic test_single_read();
      gold[5] = 32'hDEADBEEF;
      mem_a[5] <= 32'hDEADBEEF;
      mem_b[5] <= 32'hDEADBEEF;
      run_round("single_read", 2'b01, 32'h14, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic test_byte_write();
      run_round("byte_write", 2'b10, 32'h0, 32'h0, 4'h0, 32'h20, 32'h000000AB, 4'b0001);
      run_round("byte_readback", 2'b01, 32'h20, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
      checks++;
      if (a_m0_rdata[7:0] !== 8'hAB) begin
         errors++; $display("FAIL byte_lane0 got %h exp ab", a_m0_rdata[7:0]);
      end
   endtask

   task automatic test_out_of_range();
      run_round("oor_write", 2'b01, 32'h1000_0000, 32'h12345678, 4'hF, 32'h0, 32'h0, 4'h0);
      run_round("oor_alias_read", 2'b01, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
      run_round("oor_first_read", 2'b10, 32'h0, 32'h0, 4'h0, 32'h2000, 32'h0, 4'h0);
   endtask

   task automatic test_stall_hold();
      run_round("stall_hold_w", 2'b11, 32'h44, 32'h11223344, 4'hF, 32'h48, 32'h55667788, 4'hF);
      run_round("stall_hold_r", 2'b11, 32'h48, 32'h0, 4'h0, 32'h44, 32'h0, 4'h0);
   endtask

   task automatic test_contention();
      int          pk [4];
      logic [31:0] prd [4];
      logic [31:0] ca [2];
      logic [1:0]  exp_ga;
      int          k, phase;
      apply_reset();
      ca[0] = 32'h40; ca[1] = 32'h80;
      for (int i = 0; i < 4; i++) begin
         pk[i]    = (exp_last == 1) ? 0 : 1;
         exp_last = pk[i];
         prd[i]   = model_access(ca[pk[i]], 32'h0, 4'h0);
      end
      m0_valid = 1'b1; m0_addr = ca[0]; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b1; m1_addr = ca[1]; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         k = (n - 1) / 4;
         phase = (n - 1) % 4;
         exp_ga = 2'b00;
         if (phase < 3) exp_ga[pk[k]] = 1'b1;
         if (phase == 2) begin
            if (pk[k] == 0) exp_rd0 = prd[k]; else exp_rd1 = prd[k];
         end
         checks++;
         if (a_grant !== exp_ga) begin
            errors++; $display("FAIL rr_grant n=%0d got %b exp %b", n, a_grant, exp_ga);
         end
         checks++;
         if (b_grant !== ((phase < 3) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL fixed_grant n=%0d got %b exp %b", n, b_grant,
                               (phase < 3) ? 2'b01 : 2'b00);
         end
         checks++;
         if (a_m0_ready !== (phase == 2 && pk[k] == 0) || a_m1_ready !== (phase == 2 && pk[k] == 1)) begin
            errors++; $display("FAIL rr_ready n=%0d got %b%b", n, a_m1_ready, a_m0_ready);
         end
         checks++;
         if (b_m0_ready !== (phase == 2) || b_m1_ready !== 1'b0) begin
            errors++; $display("FAIL fixed_ready n=%0d got %b%b exp 0%b", n, b_m1_ready, b_m0_ready,
                               phase == 2);
         end
         checks++;
         if (a_m0_rdata !== exp_rd0 || a_m1_rdata !== exp_rd1) begin
            errors++; $display("FAIL rr_rdata n=%0d got %h/%h exp %h/%h", n, a_m0_rdata, a_m1_rdata,
                               exp_rd0, exp_rd1);
         end
         if (n == 15) begin
            m0_valid = 1'b0; m1_valid = 1'b0;
         end
      end
      $display("txn contention order=m%0d,m%0d,m%0d,m%0d", pk[0], pk[1], pk[2], pk[3]);
   endtask

   task automatic test_reset_mid_write();
      m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'hF;
      m1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (a_sram_we !== 4'hF || a_sram_ce !== 1'b1) begin
         errors++; $display("FAIL rmw_issue got we=%b ce=%b exp 1111/1", a_sram_we, a_sram_ce);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({a_m0_ready, a_m1_ready, a_sram_ce, a_busy} !== 4'b0 || a_grant !== 2'b00 ||
          a_sram_we !== 4'h0 || a_sram_addr !== 11'h0 || a_sram_wdata !== 32'h0 ||
          a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
         errors++; $display("FAIL rmw_async got g=%b we=%b ce=%b busy=%b adr=%h exp all 0",
                            a_grant, a_sram_we, a_sram_ce, a_busy, a_sram_addr);
      end
      m0_valid = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks++;
         if (a_m0_ready !== 1'b0 || a_sram_ce !== 1'b0) begin
            errors++; $display("FAIL rmw_noready n=%0d got rdy=%b ce=%b exp 0", n, a_m0_ready, a_sram_ce);
         end
      end
      resetn = 1'b1;
      exp_last = 1; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      $display("txn reset_mid_write");
      run_round("rmw_readback", 2'b01, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic test_random();
      logic [31:0] ad [2];
      logic [31:0] dd [2];
      logic [3:0]  sd [2];
      logic [1:0]  mask;
      int          sel;
      for (int r = 0; r < 40; r++) begin
         mask = 2'($urandom_range(1, 3));
         for (int p = 0; p < 2; p++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      ad[p] = $urandom | 32'h0000_2000;
            else if (sel == 1) ad[p] = 32'h0000_1FFC;
            else if (sel == 2) ad[p] = 32'h0000_2000;
            else               ad[p] = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            dd[p] = $urandom;
            sd[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         end
         run_round($sformatf("random_%0d", r), mask, ad[0], dd[0], sd[0], ad[1], dd[1], sd[1]);
      end
   endtask

   initial begin
      resetn = 1'b0;
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      exp_last = 1; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      for (int i = 0; i < 2048; i++) begin
         gold[i]  = $urandom;
         mem_a[i] <= gold[i];
         mem_b[i] <= gold[i];
      end
      test_reset();
      test_single_read();
      test_byte_write();
      test_out_of_range();
      test_stall_hold();
      test_contention();
      test_reset_mid_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysmem_arbiter.md
# sysmem_arbiter

Two-port arbiter and sequencer for the 8 KiB on-chip system SRAM (four byte-wide synchronous banks, 2048 words). It shares the banks between the CPU native memory port (port 0) and a second bus master (port 1, the planned DMA/boot loader). It serialises accesses through a fixed multi-cycle SRAM cycle and returns one registered ready pulse per transaction. It sits between the masters and the four sysmem byte banks, replacing their direct look-ahead connection.

## Interface
- ROUND_ROBIN, 1, 1 = alternate grants when both ports request; 0 = port 0 always wins.
- AW, 11, SRAM word-address width; the in-range window is byte addresses 0 to 2^(AW+2)-1.
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- m0_valid / m1_valid  in  1  request, held high with addr/wdata/wstrb stable until the matching ready.
- m0_addr / m1_addr  in  32  byte address; bits [1:0] ignored.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while ready is high, held afterwards.
- sram_addr  out  AW  word address to all four banks.
- sram_wdata  out  32  write data; byte n goes to bank n.
- sram_we  out  4  per-bank write enable.
- sram_ce  out  1  bank clock enable.
- sram_rdata  in  32  concatenated bank outputs, valid one cycle after the sampling edge.
- grant  out  2  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE: if any valid is high, select a port and register its address, data and strobes into the sram_* outputs. Set grant, then go to ISSUE. If no valid is high, stay in IDLE.
- Selection when only one port is valid: that port.
- Selection when both are valid and ROUND_ROBIN=1: the port not granted last. The last-grant pointer resets to port 1, so port 0 wins the first tie.
- Selection when both are valid and ROUND_ROBIN=0: port 0.
- ISSUE: sram_ce=1. sram_we = wstrb when the request is in range; otherwise 0. The banks sample at the end of this cycle. Next state is WAIT.
- WAIT: sram_ce=0 and sram_we=0. At the end of the cycle, capture sram_rdata into the granted port's rdata. For an out-of-range request, capture 0 instead. Next state is DONE.
- DONE: the granted port's ready is 1 for this cycle only. Clear grant at the end of the cycle, update the last-grant pointer and go to IDLE.
- In range means addr[31:AW+2] == 0.
- Out-of-range accesses complete normally with rdata 0 and no write, so the master never hangs.
- Writes also return ready. rdata after a write is the pre-write word, because the banks are read-first, and masters ignore it.
- The ungranted port's valid is ignored until the next IDLE. Its ready stays 0 and its rdata holds its old value.
- A request that stays high is never lost. Under ROUND_ROBIN=1 the waiting port is served within one transaction of the other port.

## Timing
- All outputs are registered.
- Reset values: state IDLE, every m*_ready 0, every m*_rdata 0, sram_addr 0, sram_wdata 0, sram_we 0, sram_ce 0, grant 0, busy 0, last-grant pointer at port 1.
- Latency: valid seen in IDLE at cycle t means ISSUE at t+1, WAIT at t+2, ready high at t+3 (DONE), and IDLE again at t+4.
- Back-to-back: the earliest next acceptance is t+4, so peak throughput is one access per 4 cycles.
- A master dropping valid after ready (CPU-native rule) has no effect. A valid still high at t+4 is treated as a new request.
- sram_we is nonzero for exactly one cycle (ISSUE) per write and never outside ISSUE.
- Asserting resetn low in any state immediately forces reset values. This includes a write in ISSUE: the write is abandoned and no further bank enable is issued. There is no ready for the aborted transaction.
- Simultaneous new requests arriving while busy are sampled only in IDLE.

## Test plan
- Single read: preload word 5 = 0xDEADBEEF. Drive m0 read at addr 0x14 in cycle t. Require m0_ready only at t+3 with m0_rdata 0xDEADBEEF, sram_ce high only at t+1, and grant 01 from t+1 to t+3.
- Byte write: m1 writes 0x000000AB with wstrb 0001 to 0x20. Require sram_we=0001 only at t+1 and sram_addr=8. A following m0 read of 0x20 must return the byte lane 0 as 0xAB with bytes 1-3 unchanged.
- Contention, ROUND_ROBIN=1: hold both valids high for 4 transactions. Require grant order 01,10,01,10 and ready pulses at t+3, t+7, t+11, t+15. With ROUND_ROBIN=0, port 0 receives all 4 grants.
- Out of range: m0 writes 0x12345678 to 0x1000_0000. Require ready at t+3, sram_we 0 throughout, rdata 0, and SRAM contents unchanged.
- Reset mid-write: drop resetn during ISSUE. Require all outputs at reset values immediately, no ready pulse, and a correct new transaction after release.
- Stall hold: keep m1 valid high while m0 is granted. Require m1_ready to stay 0 and m1_rdata to stay unchanged until m1's own DONE.
